mux2_rr_arbiter: RTL

//  Round-robin arbiter that shares the 8-bit 2:1 operand mux between two requesters.
//  - Drives the mux select, captures the selected byte into an output register and

---
 rtl/mux2_rr_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Round-robin arbiter sharing one DATA_W-bit 2:1 operand mux between two
//   requesters. The granted byte is captured into an output register and
//   offered downstream with a valid/ready handshake.
//
// Optional feature macro: MUX2_LOCK_EN (burst lock with LOCK_MAX beat cap).
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous active-high reset
//   req1      in   1       requester 1 has a word on ip1
//   ip1       in   DATA_W  requester 1 data
//   ack1      out  1       combinational: ip1 captured this cycle
//   req2      in   1       requester 2 has a word on ip2
//   ip2       in   DATA_W  requester 2 data
//   ack2      out  1       combinational: ip2 captured this cycle
//   op        out  DATA_W  registered output data
//   op_valid  out  1       op holds an untaken word
//   op_ready  in   1       consumer accepts op this cycle
//   sel       out  1       registered source of last captured word (0=ip1, 1=ip2)
//   lock1     in   1       [MUX2_LOCK_EN] requester 1 burst lock
//   lock2     in   1       [MUX2_LOCK_EN] requester 2 burst lock
module mux2_rr_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic [DATA_W-1:0] ip1,
  output logic              ack1,
  input  logic              req2,
  input  logic [DATA_W-1:0] ip2,
  output logic              ack2,
  output logic [DATA_W-1:0] op,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              sel
`ifdef MUX2_LOCK_EN
  ,
  input  logic              lock1,
  input  logic              lock2
`endif
);

  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("LOCK_MAX must be at least 1");
  end

  // State bit 0 is the output-valid flag; bit 1 (lock build only) is the lock flag.
`ifdef MUX2_LOCK_EN
  localparam int unsigned ST_W  = 2;
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
`else
  localparam int unsigned ST_W  = 1;
`endif

  localparam logic [ST_W-1:0] S_EMPTY = ST_W'(0);
  localparam logic [ST_W-1:0] S_FULL  = ST_W'(1);
`ifdef MUX2_LOCK_EN
  localparam logic [ST_W-1:0] S_LOCKED_E = 2'b10;  // locked, output drained
  localparam logic [ST_W-1:0] S_LOCKED_F = 2'b11;  // locked, output holds a word
`endif

  logic [ST_W-1:0]   r_state;
  logic [DATA_W-1:0] r_op;
  logic              r_sel;
  logic              r_last_grant;

  logic [ST_W-1:0]   w_state_nxt;
  logic [DATA_W-1:0] w_op_nxt;
  logic              w_sel_nxt;
  logic              w_last_nxt;
  logic              w_valid_nxt;
  logic              w_req1;
  logic              w_req2;
  logic              w_load;
  logic              w_grant;

`ifdef MUX2_LOCK_EN
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_owner_lock;
  logic              w_lock_hold;
  logic              w_locked_nxt;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_op         <= '0;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;  // makes ip1 win the first tie
`ifdef MUX2_LOCK_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_sel        <= w_sel_nxt;
      r_last_grant <= w_last_nxt;
`ifdef MUX2_LOCK_EN
      r_cnt        <= w_cnt_nxt;
`endif
    end
  end

  // Arbitration, capture and next-state logic.
  always_comb begin
    w_req1      = req1;
    w_req2      = req2;
    w_valid_nxt = r_state[0];
    w_op_nxt    = r_op;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last_grant;
    w_state_nxt = r_state;
`ifdef MUX2_LOCK_EN
    w_cnt_nxt    = '0;
    w_cnt_inc    = r_cnt + CNT_W'(1);
    w_locked_nxt = 1'b0;
    w_owner_lock = r_last_grant ? lock2 : lock1;
    // Lock only binds while the owner keeps its lock line high.
    w_lock_hold  = r_state[1] & w_owner_lock;
    if (w_lock_hold) begin
      if (r_last_grant) w_req1 = 1'b0;
      else              w_req2 = 1'b0;
    end
`endif

    w_load  = (!r_state[0] | op_ready) & (w_req1 | w_req2) & !rst;
    // Tie goes to the side that did not win last.
    w_grant = (w_req1 & w_req2) ? !r_last_grant : w_req2;
    ack1    = w_load & !w_grant;
    ack2    = w_load & w_grant;

    if (w_load) begin
      w_op_nxt    = w_grant ? ip2 : ip1;
      w_sel_nxt   = w_grant;
      w_last_nxt  = w_grant;
      w_valid_nxt = 1'b1;
    end else if (r_state[0] & op_ready) begin
      w_valid_nxt = 1'b0;
    end

`ifdef MUX2_LOCK_EN
    if (w_lock_hold) begin
      w_locked_nxt = 1'b1;
      w_cnt_nxt    = r_cnt;
      if (w_load) begin
        // Beat cap reached: release; last_grant already favours the other side.
        if (w_cnt_inc == CNT_W'(LOCK_MAX)) begin
          w_locked_nxt = 1'b0;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
    end else if (w_load && (w_grant ? lock2 : lock1) && (LOCK_MAX > 1)) begin
      // First locked beat counts as one; a cap of one never holds the bus.
      w_locked_nxt = 1'b1;
      w_cnt_nxt    = CNT_W'(1);
    end
    w_state_nxt = {w_locked_nxt, w_valid_nxt};
`else
    w_state_nxt = w_valid_nxt ? S_FULL : S_EMPTY;
`endif
  end

  assign op       = r_op;
  assign op_valid = r_state[0];
  assign sel      = r_sel;

endmodule
